// File: rtl/fmad_pkg.sv
// ----------------------------------------------------------------------------
// fmad_pkg : shared constants, flag indices and FSM state for fmad_seq
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fmad_pkg;

  localparam int FMAD_LAT = 4;
  localparam int FMAD_GAP = 2;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_NV = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/fmad_rfifo.sv
// ----------------------------------------------------------------------------
// fmad_rfifo : registered synchronous FIFO, wrap-bit pointers, no bypass
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fmad_rfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign count = r_wptr - r_rptr;
  assign dout  = r_mem[r_rptr[AW-1:0]];

  // A pop frees the slot a full-FIFO push overwrites at the same edge.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/fmad_seq.sv
// ----------------------------------------------------------------------------
// fmad_seq : issue/retire sequencer driving the fmad core with credit flow
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fmad_seq
  import fmad_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [31:0]      in_z,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rslt,
  output logic [4:0]       out_flag,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic             busy,
  output logic             fma_req,
  output logic [31:0]      fma_x,
  output logic [31:0]      fma_y,
  output logic [31:0]      fma_z,
  input  logic [31:0]      fma_rslt,
  input  logic [4:0]       fma_flag
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = 32 + 5 + TAG_W;
  localparam logic [4:0] C_FLG_MASK = (5'd1 << FLG_NV) | (5'd1 << FLG_OF) |
                                      (5'd1 << FLG_UF) | (5'd1 << FLG_NX);

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic       w_fma_req;
  logic       w_can_take;
  logic       w_credit_ok;
  logic       w_accept;
  logic       w_pop;

  logic [31:0]      r_x;
  logic [31:0]      r_y;
  logic [31:0]      r_z;
  logic [TAG_W-1:0] r_tag;
  logic [CW-1:0]    r_cred;
  logic [4:0]       r_fflags;

  logic [FMAD_LAT-1:0]             r_pv;
  logic [FMAD_LAT-1:0][TAG_W-1:0]  r_ptag;
  logic                            w_push;
  logic [4:0]                      w_push_flag;
  logic [FW-1:0]                   w_fifo_din;
  logic [FW-1:0]                   w_fifo_dout;
  logic                            w_full;
  logic                            w_empty;
  logic [CW-1:0]                   w_count;

  // Handshake: ready depends only on registered state, never on in_valid/out_ready.
  assign w_can_take  = (r_state == ST_IDLE) || (r_state == ST_HOLD);
  assign w_credit_ok = (r_cred < CW'(DEPTH));
  assign in_ready    = w_can_take & w_credit_ok;
  assign w_accept    = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fma_req   = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        w_fma_req   = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD:  w_state_nxt = w_accept ? ST_ISSUE : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign fma_req = w_fma_req;

  // Operand registers feed the core directly; stable through ISSUE and HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_tag <= '0;
    end else if (w_accept) begin
      r_x   <= in_x;
      r_y   <= in_y;
      r_z   <= in_z;
      r_tag <= in_tag;
    end
  end

  assign fma_x = r_x;
  assign fma_y = r_y;
  assign fma_z = r_z;

  // Occupancy plus in-flight ops; a push moves an op between the two, net zero.
  always_ff @(posedge clk) begin
    if (reset) r_cred <= '0;
    else       r_cred <= r_cred + CW'(w_accept) - CW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv   <= '0;
      r_ptag <= '0;
    end else begin
      r_pv   <= {r_pv[FMAD_LAT-2:0], w_fma_req};
      r_ptag <= {r_ptag[FMAD_LAT-2:0], r_tag};
    end
  end

  assign w_push      = r_pv[FMAD_LAT-1];
  assign w_push_flag = fma_flag & C_FLG_MASK;
  assign w_fifo_din  = {fma_rslt, w_push_flag, r_ptag[FMAD_LAT-1]};

  fmad_rfifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_rfifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (w_fifo_din),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign out_valid                    = ~w_empty;
  assign {out_rslt, out_flag, out_tag} = w_fifo_dout;

  always_ff @(posedge clk) begin
    if (reset)           r_fflags <= '0;
    else if (w_push)     r_fflags <= (fflags_clr ? 5'd0 : r_fflags) | w_push_flag;
    else if (fflags_clr) r_fflags <= '0;
  end

  assign fflags = r_fflags;
  assign busy   = (r_state != ST_IDLE) || (r_cred != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && w_full && !w_pop));
  a_credit: assert property (@(posedge clk) disable iff (reset)
    (w_count <= r_cred) && (r_cred <= CW'(DEPTH)));
  a_req_gap: assert property (@(posedge clk) disable iff (reset)
    fma_req |-> !$past(fma_req, FMAD_GAP - 1));

endmodule

`default_nettype wire

// File: tb/tb_fmad_seq.sv
// ----------------------------------------------------------------------------
// tb_fmad_seq : fmad_seq bench with a stand-in 4-cycle core and reference model
// Revision    : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fmad_seq;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_x = '0;
  logic [31:0]      in_y = '0;
  logic [31:0]      in_z = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_rslt;
  logic [4:0]       out_flag;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       fflags;
  logic             fflags_clr = 1'b0;
  logic             busy;
  logic             fma_req;
  logic [31:0]      fma_x;
  logic [31:0]      fma_y;
  logic [31:0]      fma_z;
  logic [31:0]      fma_rslt;
  logic [4:0]       fma_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fmad_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rslt(out_rslt), .out_flag(out_flag), .out_tag(out_tag),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy),
    .fma_req(fma_req), .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_rslt(fma_rslt), .fma_flag(fma_flag)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Golden x*y+z: known IEEE vectors from a table, otherwise integer arithmetic.
  function automatic logic [36:0] core_fn(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
    if (x == 32'h3F800000 && y == 32'h40000000 && z == 32'h40400000) return {5'h00, 32'h40A00000};
    if (x == 32'h7F800001 && y == 32'h3F800000 && z == 32'h0)        return {5'h10, 32'h7FC00001};
    if (x == 32'h7F7FFFFF && y == 32'h40000000 && z == 32'h0)        return {5'h05, 32'h7F800000};
    if (x == 32'h7F800000 && y == 32'h0 && z == 32'h3F800000)        return {5'h10, 32'hFFC00000};
    return {x[4], 1'b0, x[2:0] ^ y[2:0], x * y + z};
  endfunction

  // Stand-in core: result readable 4 cycles after req, garbage otherwise.
  logic [36:0] core_pipe [4];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) core_pipe[i] <= 37'h1F_DEADBEEF;
    end else begin
      core_pipe[0] <= fma_req ? core_fn(fma_x, fma_y, fma_z) : 37'h1F_DEADBEEF;
      for (int i = 1; i < 4; i++) core_pipe[i] <= core_pipe[i-1];
    end
  end
  assign {fma_flag, fma_rslt} = core_pipe[3];

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      rslt;
    logic [4:0]       flag;
    int               push_at;
    int               vis_at;
  } ent_t;

  // Reference model: accepted-but-unpopped ops with their push/visibility cycles.
  initial begin
    ent_t        mq[$];
    int          cyc = 0;
    bit          acc_prev = 1'b0;
    bit          armed = 1'b0;
    bit          exp_rdy, exp_ov, fire, pop, pushed;
    logic [31:0] lx = '0, ly = '0, lz = '0;
    logic [4:0]  mflags = '0, pf;
    logic [36:0] r;
    forever begin
      @(negedge clk);
      exp_rdy = !acc_prev && (mq.size() < DEPTH);
      exp_ov  = (mq.size() != 0) && (mq[0].vis_at <= cyc);
      if (armed) begin
        chk("in_ready", in_ready, exp_rdy);
        chk("fma_req", fma_req, acc_prev);
        chk("fma_x", fma_x, lx);
        chk("fma_y", fma_y, ly);
        chk("fma_z", fma_z, lz);
        chk("busy", busy, mq.size() != 0);
        chk("fflags", fflags, mflags);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
          chk("out_rslt", out_rslt, mq[0].rslt);
          chk("out_flag", out_flag, mq[0].flag);
          chk("out_tag", out_tag, mq[0].tag);
        end
      end
      if (reset) begin
        mq.delete();
        cyc = 0; acc_prev = 1'b0; armed = 1'b1;
        lx = '0; ly = '0; lz = '0; mflags = '0;
      end else begin
        fire = in_valid && exp_rdy;
        pop  = out_ready && exp_ov;
        pushed = 1'b0; pf = '0;
        foreach (mq[i]) if (mq[i].push_at == cyc) begin pushed = 1'b1; pf = mq[i].flag; end
        if (pushed)          mflags = (fflags_clr ? 5'd0 : mflags) | pf;
        else if (fflags_clr) mflags = '0;
        if (pop) void'(mq.pop_front());
        if (fire) begin
          r = core_fn(in_x, in_y, in_z);
          mq.push_back('{in_tag, r[31:0], r[36:32], cyc + 5, cyc + 6});
          lx = in_x; ly = in_y; lz = in_z;
        end
        acc_prev = fire;
        cyc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                       input logic [TAG_W-1:0] t);
    bit a;
    int n = 0;
    in_x = x; in_y = y; in_z = z; in_tag = t; in_valid = 1'b1;
    do begin a = in_ready; step(); n++; end while (!a && n < 50);
    in_valid = 1'b0;
    if (!a) begin total++; bad++; $display("FAIL issue_timeout: got no accept want accept"); end
  endtask

  task automatic wait_idle();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (busy && n < 200) begin step(); n++; end
    if (busy) begin total++; bad++; $display("FAIL drain_timeout: got busy=1 want 0"); end
    step(); step();
  endtask

  task automatic clr_pulse();
    fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int               nt, acc20, sent;
    bit               fire, ir2, ir8;
    logic [31:0]      reqmask;
    logic [TAG_W-1:0] got[$];

    repeat (3) step();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_fma_x", fma_x, 0);

    // 1.0*2.0+3.0 = 5.0, visible in cycle 6
    issue(32'h3F800000, 32'h40000000, 32'h40400000, 4'd3);
    repeat (4) step();
    chk("t1_ov_c5", out_valid, 0);
    chk("t1_core_rslt", fma_rslt, 32'h40A00000);
    step();
    chk("t1_ov_c6", out_valid, 1);
    chk("t1_rslt", out_rslt, 32'h40A00000);
    chk("t1_flag", out_flag, 0);
    chk("t1_tag", out_tag, 3);
    chk("t1_fflags", fflags, 0);
    wait_idle();

    // sNaN propagation
    issue(32'h7F800001, 32'h3F800000, 32'h0, 4'd5);
    repeat (5) step();
    chk("t2_rslt", out_rslt, 32'h7FC00001);
    chk("t2_flag", out_flag, 5'h10);
    chk("t2_fflags", fflags, 5'h10);
    wait_idle();

    // overflow then inf*0, sticky accumulation
    clr_pulse();
    chk("t3_clr", fflags, 0);
    issue(32'h7F7FFFFF, 32'h40000000, 32'h0, 4'd1);
    issue(32'h7F800000, 32'h0, 32'h3F800000, 4'd2);
    repeat (3) step();
    chk("t3_fflags_of", fflags, 5'h05);
    repeat (2) step();
    chk("t3_fflags_acc", fflags, 5'h15);
    wait_idle();

    // same pair, clear coincident with the second push
    clr_pulse();
    issue(32'h7F7FFFFF, 32'h40000000, 32'h0, 4'd1);
    issue(32'h7F800000, 32'h0, 32'h3F800000, 4'd2);
    repeat (4) step();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    chk("t3_fflags_clrpush", fflags, 5'h10);
    wait_idle();

    // 8 back-to-back ops with the output stalled, then drained
    nt = 0; acc20 = 0; reqmask = '0; ir2 = 1'b0; ir8 = 1'b1;
    for (int k = 0; k < 80; k++) begin
      out_ready = (k >= 20);
      in_valid  = (nt < 8);
      in_x = 32'h100 + nt; in_y = nt + 3; in_z = nt * 7; in_tag = TAG_W'(nt);
      fire = in_valid && in_ready;
      if (k < 20) reqmask[k] = fma_req;
      if (k == 2) ir2 = in_ready;
      if (k == 8) ir8 = in_ready;
      if (out_valid && out_ready) got.push_back(out_tag);
      step();
      if (fire) nt++;
      if (k == 19) acc20 = nt;
    end
    in_valid = 1'b0;
    chk("t4_req_pattern", reqmask, 32'h0000_00AA);
    chk("t4_ready_hold", ir2, 1);
    chk("t4_ready_stall", ir8, 0);
    chk("t4_accepts_stalled", acc20, 4);
    chk("t4_pop_count", got.size(), 8);
    foreach (got[i]) chk("t4_pop_order", got[i], i);
    wait_idle();

    // reset in HOLD with two ops in flight
    out_ready = 1'b0;
    issue(32'h11, 32'h22, 32'h33, 4'd1);
    issue(32'h44, 32'h55, 32'h66, 4'd2);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_fflags", fflags, 0);
    repeat (10) begin
      chk("t5_no_out", out_valid, 0);
      step();
    end

    // random traffic against the model
    sent = 0;
    for (int k = 0; k < 600 && sent < 60; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_x = $urandom(); in_y = $urandom(); in_z = $urandom(); in_tag = TAG_W'($urandom());
      fire = in_valid && in_ready;
      step();
      if (fire) sent++;
    end
    chk("rnd_sent", sent, 60);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
